// File: rtl/static_pin_tester_pkg.sv
// -----------------------------------------------------------------------------
// static_pin_tester_pkg
// Shared types for the static pin tester sequencer.
//   pin_state_t : per-pin verdict, encoded as {lo_sample, hi_sample}
//   seq_state_t : sequencer FSM states
//   MAX_WIDTH   : largest number of pins tested in parallel
//   max_int     : helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package static_pin_tester_pkg;

    localparam int MAX_WIDTH = 32;

    // {lo_sample, hi_sample}: a pin that reads back what was last driven is
    // held only by its keeper (floating); the inverse pattern is anomalous.
    typedef enum logic [1:0] {
        PIN_GND     = 2'b00,
        PIN_FLOAT   = 2'b01,
        PIN_ANOMALY = 2'b10,
        PIN_VCC     = 2'b11
    } pin_state_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRIVE_LO = 3'd1,
        FLOAT_LO = 3'd2,
        DRIVE_HI = 3'd3,
        FLOAT_HI = 3'd4
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/static_pin_sync.sv
// -----------------------------------------------------------------------------
// static_pin_sync
// WIDTH-bit two-flop synchronizer for the IOBUF read-back, which is
// asynchronous to the sequencer clock. Each bit is synchronized on its own;
// the sequencer only samples after a settle window, so no bus coherency is
// needed across bits.
// Ports:
//   clk    in   1      sequencer clock
//   rst_n  in   1      async active-low reset, clears both stages to 0
//   raw    in   WIDTH  asynchronous pin values
//   synced out  WIDTH  pin values after two flops
// -----------------------------------------------------------------------------
module static_pin_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/static_pin_test_sequencer.sv
// -----------------------------------------------------------------------------
// static_pin_test_sequencer
// Runs the drive-low / release / sample / drive-high / release / sample
// procedure on WIDTH pins in parallel and reports a 2-bit verdict per pin
// (see pin_state_t). One start pulse launches a run; done pulses when the
// result register has been updated.
//
// Handshake: start is a single-cycle request accepted only in IDLE with
// abort low; busy is high from the cycle after acceptance until the run
// finishes or is aborted; done is a single-cycle pulse coincident with
// busy falling and result_valid rising. abort is a level that returns the
// sequencer to IDLE on the next clock with pins released and no done pulse.
//
// Ports:
//   S_AXI_ACLK     in   1        clock
//   S_AXI_ARESETN  in   1        async active-low reset
//   start          in   1        begin a run (ignored while busy)
//   abort          in   1        terminate the run, release pins
//   busy           out  1        run in progress
//   done           out  1        result updated this cycle
//   result_valid   out  1        result holds a completed run
//   result         out  2*WIDTH  per pin {lo_sample, hi_sample}
//   value_to_drive out  WIDTH    IOBUF I inputs
//   tristate       out  WIDTH    IOBUF T inputs (1 = released)
//   value_read     in   WIDTH    IOBUF O outputs (asynchronous)
//   seq_state      out  3        current FSM state (debug)
// -----------------------------------------------------------------------------
module static_pin_test_sequencer
    import static_pin_tester_pkg::*;
#(
    parameter int WIDTH         = 1,
    parameter int DRIVE_CYCLES  = 1000,
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESETN,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               result_valid,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   value_to_drive,
    output logic [WIDTH-1:0]   tristate,
    input  logic [WIDTH-1:0]   value_read,
    output logic [2:0]         seq_state
);

    localparam int CNT_MAX = max_int(DRIVE_CYCLES, SETTLE_CYCLES);
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Each phase lasts N clocks: load N-1 on entry, leave when the count is 0.
    localparam logic [CW-1:0] DRIVE_LOAD  = CW'(DRIVE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_next;
    logic [WIDTH-1:0]   lo_sample;
    logic [WIDTH-1:0]   lo_sample_next;
    logic [WIDTH-1:0]   synced;

    logic               busy_next;
    logic               done_next;
    logic               result_valid_next;
    logic [2*WIDTH-1:0] result_next;
    logic [WIDTH-1:0]   value_to_drive_next;
    logic [WIDTH-1:0]   tristate_next;

    static_pin_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk    (S_AXI_ACLK),
        .rst_n  (S_AXI_ARESETN),
        .raw    (value_read),
        .synced (synced)
    );

    assign seq_state = state;

    // -------------------------------------------------------------------------
    // Next-state, counter, sample and output computation
    // -------------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        lo_sample_next    = lo_sample;
        result_next       = result;
        result_valid_next = result_valid;
        done_next         = 1'b0;

        case (state)
            IDLE: begin
                // abort wins over a coincident start
                if (start && !abort) begin
                    state_next        = DRIVE_LO;
                    cnt_next          = DRIVE_LOAD;
                    result_valid_next = 1'b0;
                end
            end

            default: begin
                if (abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    case (state)
                        DRIVE_LO: begin
                            state_next = FLOAT_LO;
                            cnt_next   = SETTLE_LOAD;
                        end
                        FLOAT_LO: begin
                            state_next     = DRIVE_HI;
                            cnt_next       = DRIVE_LOAD;
                            lo_sample_next = synced;
                        end
                        DRIVE_HI: begin
                            state_next = FLOAT_HI;
                            cnt_next   = SETTLE_LOAD;
                        end
                        FLOAT_HI: begin
                            state_next        = IDLE;
                            cnt_next          = '0;
                            done_next         = 1'b1;
                            result_valid_next = 1'b1;
                            for (int i = 0; i < WIDTH; i++) begin
                                result_next[2*i+1] = lo_sample[i];
                                result_next[2*i]   = synced[i];
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end
        endcase

        // Pin controls are registered from the state being entered so they
        // line up exactly with the state register.
        busy_next           = (state_next != IDLE);
        tristate_next       = ((state_next == DRIVE_LO) || (state_next == DRIVE_HI)) ? '0 : '1;
        value_to_drive_next = (state_next == DRIVE_HI) ? '1 : '0;
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state          <= IDLE;
            cnt            <= '0;
            lo_sample      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_valid   <= 1'b0;
            result         <= '0;
            value_to_drive <= '0;
            tristate       <= '1;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            lo_sample      <= lo_sample_next;
            busy           <= busy_next;
            done           <= done_next;
            result_valid   <= result_valid_next;
            result         <= result_next;
            value_to_drive <= value_to_drive_next;
            tristate       <= tristate_next;
        end
    end

endmodule
